// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Moore FSM sequencing a multicycle MIPS datapath (shared memory, IR, A/B,
// ALUOut and MDR registers). The opcode is decoded once per instruction and
// the FSM drives the per-cycle datapath enables and mux selects.
// Supported: R-type, LW, SW, BEQ, J. Unsupported opcodes park the FSM in HALT
// and set a sticky illegal_op flag. An optional memory-ready handshake
// stretches FETCH, MEMRD and MEMWR.
//
// Parameters
//   USE_MEM_READY  0: single-cycle memory, mem_ready ignored
//                  1: memory states wait for mem_ready
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-high reset
//   opcode[5:0]    in   IR[31:26], sampled only in DECODE and MEMADR
//   mem_ready      in   memory access completes this cycle
//   pc_write       out  unconditional PC load
//   pc_write_cond  out  PC load if ALU zero (BEQ)
//   i_or_d         out  memory address select: 0 PC, 1 ALUOut
//   mem_read       out  memory read strobe
//   mem_write      out  memory write strobe
//   ir_write       out  IR load
//   mem_to_reg     out  register write data: 0 ALUOut, 1 MDR
//   reg_dst        out  destination register: 0 rt, 1 rd
//   reg_write      out  register file write enable
//   alu_src_a      out  ALU A: 0 PC, 1 reg A
//   alu_src_b[1:0] out  ALU B: 00 B, 01 4, 10 imm, 11 imm<<2
//   alu_op[1:0]    out  to alu_control: 00 add, 01 sub, 10 funct
//   pc_source[1:0] out  PC next: 00 ALU, 01 ALUOut, 10 jump target
//   instr_done     out  pulse in the final cycle of each instruction
//   illegal_op     out  sticky unsupported-opcode flag
//   state[3:0]     out  current state code (debug)
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int unsigned USE_MEM_READY = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_illegal;
    logic   w_set_illegal;

    logic       w_mem_rdy;
    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_i_or_d;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_mem_to_reg;
    logic       w_reg_dst;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic [1:0] w_pc_source;
    logic       w_instr_done;

    // Without the handshake every memory access is treated as completing at once.
    assign w_mem_rdy = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

    // State register and sticky illegal-opcode flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Next-state and per-state datapath control decode.
    always_comb begin
        w_next          = S_FETCH;
        w_set_illegal   = 1'b0;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_i_or_d        = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_dst       = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_alu_op        = 2'b00;
        w_pc_source     = 2'b00;
        w_instr_done    = 1'b0;

        case (r_state)
            S_FETCH: begin
                // PC+4 and IR load are qualified by ready so they happen once per fetch.
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                w_ir_write  = w_mem_rdy;
                w_pc_write  = w_mem_rdy;
                w_next      = w_mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut while the opcode is decoded.
                w_alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    default: begin
                        w_next        = S_HALT;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_next      = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_mem_read = 1'b1;
                w_i_or_d   = 1'b1;
                w_next     = w_mem_rdy ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWR: begin
                w_mem_write  = 1'b1;
                w_i_or_d     = 1'b1;
                w_instr_done = w_mem_rdy;
                w_next       = w_mem_rdy ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
                w_next      = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = 2'b01;
                w_pc_write_cond = 1'b1;
                w_pc_source     = 2'b01;
                w_instr_done    = 1'b1;
                w_next          = S_FETCH;
            end
            S_JUMP: begin
                w_pc_write   = 1'b1;
                w_pc_source  = 2'b10;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                // Unused encodings recover to FETCH with all controls idle.
                w_next = S_FETCH;
            end
        endcase
    end

    // Reset gates every output so nothing partial reaches the datapath mid-reset.
    assign pc_write      = w_pc_write      & ~reset;
    assign pc_write_cond = w_pc_write_cond & ~reset;
    assign i_or_d        = w_i_or_d        & ~reset;
    assign mem_read      = w_mem_read      & ~reset;
    assign mem_write     = w_mem_write     & ~reset;
    assign ir_write      = w_ir_write      & ~reset;
    assign mem_to_reg    = w_mem_to_reg    & ~reset;
    assign reg_dst       = w_reg_dst       & ~reset;
    assign reg_write     = w_reg_write     & ~reset;
    assign alu_src_a     = w_alu_src_a     & ~reset;
    assign alu_src_b     = reset ? 2'b00 : w_alu_src_b;
    assign alu_op        = reset ? 2'b00 : w_alu_op;
    assign pc_source     = reset ? 2'b00 : w_pc_source;
    assign instr_done    = w_instr_done    & ~reset;
    assign illegal_op    = r_illegal       & ~reset;
    assign state         = reset ? 4'd0 : STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
// Two instances (no handshake / with handshake) driven from per-cycle plans.
// Each plan is built from instruction-level phase lists with random stalls,
// random don't-care opcodes, mid-instruction resets and illegal opcodes.
// A driver applies each planned cycle and queues its expected outputs; a
// monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multicycle_control;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
        logic [3:0] state;
    } outs_t;

    typedef struct packed {
        logic       rst;
        logic       rdy;
        logic [5:0] op;
        outs_t      exp;
    } cyc_t;

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4,
                   P_MEMWR = 5, P_EXEC = 6, P_ALUWB = 7, P_BRANCH = 8, P_JUMP = 9, P_HALT = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, rst1, rdy0, rdy1;
    logic [5:0] op0, op1;

    logic       pcw0, pcwc0, iod0, mrd0, mwr0, irw0, m2r0, rdst0, rw0, asa0, done0, ill0;
    logic [1:0] asb0, aop0, pcs0;
    logic [3:0] st0;
    logic       pcw1, pcwc1, iod1, mrd1, mwr1, irw1, m2r1, rdst1, rw1, asa1, done1, ill1;
    logic [1:0] asb1, aop1, pcs1;
    logic [3:0] st1;

    multicycle_control #(.USE_MEM_READY(0)) u_dut0 (
        .clk(clk), .reset(rst0), .opcode(op0), .mem_ready(rdy0),
        .pc_write(pcw0), .pc_write_cond(pcwc0), .i_or_d(iod0), .mem_read(mrd0),
        .mem_write(mwr0), .ir_write(irw0), .mem_to_reg(m2r0), .reg_dst(rdst0),
        .reg_write(rw0), .alu_src_a(asa0), .alu_src_b(asb0), .alu_op(aop0),
        .pc_source(pcs0), .instr_done(done0), .illegal_op(ill0), .state(st0)
    );

    multicycle_control #(.USE_MEM_READY(1)) u_dut1 (
        .clk(clk), .reset(rst1), .opcode(op1), .mem_ready(rdy1),
        .pc_write(pcw1), .pc_write_cond(pcwc1), .i_or_d(iod1), .mem_read(mrd1),
        .mem_write(mwr1), .ir_write(irw1), .mem_to_reg(m2r1), .reg_dst(rdst1),
        .reg_write(rw1), .alu_src_a(asa1), .alu_src_b(asb1), .alu_op(aop1),
        .pc_source(pcs1), .instr_done(done1), .illegal_op(ill1), .state(st1)
    );

    outs_t act0, act1;
    assign act0 = {pcw0, pcwc0, iod0, mrd0, mwr0, irw0, m2r0, rdst0, rw0, asa0,
                   asb0, aop0, pcs0, done0, ill0, st0};
    assign act1 = {pcw1, pcwc1, iod1, mrd1, mwr1, irw1, m2r1, rdst1, rw1, asa1,
                   asb1, aop1, pcs1, done1, ill1, st1};

    cyc_t  pq0[$], pq1[$];
    outs_t eq0[$], eq1[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc0 = 0, cyc1 = 0;

    // Control word the datapath needs in each phase; 'rdy' is whether the
    // memory access of that cycle completes, 'ill' the sticky flag.
    function automatic outs_t phase_out(int ph, bit rdy, bit ill);
        outs_t o;
        o            = '0;
        o.state      = 4'(ph);
        o.illegal_op = ill;
        case (ph)
            P_FETCH:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
            P_DECODE: o.alu_src_b = 2'b11;
            P_MEMADR: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            P_MEMRD:  begin o.mem_read = 1; o.i_or_d = 1; end
            P_MEMWB:  begin o.reg_write = 1; o.mem_to_reg = 1; o.instr_done = 1; end
            P_MEMWR:  begin o.mem_write = 1; o.i_or_d = 1; o.instr_done = rdy; end
            P_EXEC:   begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            P_ALUWB:  begin o.reg_write = 1; o.reg_dst = 1; o.instr_done = 1; end
            P_BRANCH: begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1;
                            o.pc_source = 2'b01; o.instr_done = 1; end
            P_JUMP:   begin o.pc_write = 1; o.pc_source = 2'b10; o.instr_done = 1; end
            default:  ;
        endcase
        return o;
    endfunction

    function automatic cyc_t mk(bit rst, bit rdy, logic [5:0] op, outs_t e);
        cyc_t c;
        c.rst = rst; c.rdy = rdy; c.op = op; c.exp = e;
        return c;
    endfunction

    function automatic bit is_legal(logic [5:0] op);
        return (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
               (op == 6'b000100) || (op == 6'b000010);
    endfunction

    task automatic push_plan(int d, cyc_t c);
        if (d == 0) pq0.push_back(c);
        else        pq1.push_back(c);
    endtask

    task automatic add_reset(int d, int n);
        for (int i = 0; i < n; i++) push_plan(d, mk(1'b1, 1'($urandom), 6'($urandom), '0));
    endtask

    // Plan one instruction for DUT d. cls: 0 R, 1 LW, 2 SW, 3 BEQ, 4 J, 5 illegal, -1 random.
    task automatic gen_instr(int d, int cls_in, bit allow_cut);
        int         ph[$];
        cyc_t       loc[$];
        int         cls;
        logic [5:0] op;
        int         nst;
        bit         stallable;
        cls = cls_in;
        if (cls < 0) begin
            cls = $urandom_range(0, 11);
            cls = (cls < 3) ? 0 : (cls < 5) ? 1 : (cls < 7) ? 2 : (cls < 9) ? 3 : (cls < 11) ? 4 : 5;
        end
        case (cls)
            0: begin op = 6'b000000; ph = '{P_FETCH, P_DECODE, P_EXEC, P_ALUWB}; end
            1: begin op = 6'b100011; ph = '{P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB}; end
            2: begin op = 6'b101011; ph = '{P_FETCH, P_DECODE, P_MEMADR, P_MEMWR}; end
            3: begin op = 6'b000100; ph = '{P_FETCH, P_DECODE, P_BRANCH}; end
            4: begin op = 6'b000010; ph = '{P_FETCH, P_DECODE, P_JUMP}; end
            default: begin
                op = (cls_in == 5) ? 6'b111111 : 6'($urandom);
                while (is_legal(op)) op = 6'($urandom);
                ph = '{P_FETCH, P_DECODE};
            end
        endcase
        foreach (ph[i]) begin
            logic [5:0] cop;
            cop       = (ph[i] == P_DECODE || ph[i] == P_MEMADR) ? op : 6'($urandom);
            stallable = (d == 1) && (ph[i] == P_FETCH || ph[i] == P_MEMRD || ph[i] == P_MEMWR);
            nst       = 0;
            if (stallable && $urandom_range(0, 2) == 0) nst = $urandom_range(1, 3);
            for (int k = 0; k < nst; k++)
                loc.push_back(mk(1'b0, 1'b0, 6'($urandom), phase_out(ph[i], 1'b0, 1'b0)));
            loc.push_back(mk(1'b0, stallable ? 1'b1 : 1'($urandom), cop, phase_out(ph[i], 1'b1, 1'b0)));
        end
        if (cls == 5) begin
            int nh = $urandom_range(1, 4);
            for (int k = 0; k < nh; k++)
                loc.push_back(mk(1'b0, 1'($urandom), 6'($urandom), phase_out(P_HALT, 1'b1, 1'b1)));
        end
        if (cls != 5 && allow_cut && $urandom_range(0, 6) == 0) begin
            int cut = $urandom_range(1, loc.size() - 1);
            while (loc.size() > cut) void'(loc.pop_back());
            foreach (loc[i]) push_plan(d, loc[i]);
            add_reset(d, $urandom_range(1, 2));
        end else begin
            foreach (loc[i]) push_plan(d, loc[i]);
            if (cls == 5) add_reset(d, $urandom_range(1, 2));
        end
    endtask

    // Driver: apply one planned cycle per DUT just after each rising edge.
    initial begin
        cyc_t c;
        forever begin
            @(posedge clk);
            #1;
            if (pq0.size() > 0) begin
                c = pq0.pop_front();
                rst0 = c.rst; rdy0 = c.rdy; op0 = c.op;
                eq0.push_back(c.exp);
            end
            if (pq1.size() > 0) begin
                c = pq1.pop_front();
                rst1 = c.rst; rdy1 = c.rdy; op1 = c.op;
                eq1.push_back(c.exp);
            end
        end
    end

    // Monitor: compare every presented cycle against the scoreboard.
    initial begin
        outs_t e;
        forever begin
            @(negedge clk);
            if (eq0.size() > 0) begin
                e = eq0.pop_front();
                tests++;
                if (act0 !== e) begin
                    fails++;
                    $display("FAIL dut0_cycle%0d: got %h (state %0d) required %h (state %0d)",
                             cyc0, act0, act0.state, e, e.state);
                end
                cyc0++;
            end
            if (eq1.size() > 0) begin
                e = eq1.pop_front();
                tests++;
                if (act1 !== e) begin
                    fails++;
                    $display("FAIL dut1_cycle%0d: got %h (state %0d) required %h (state %0d)",
                             cyc1, act1, act1.state, e, e.state);
                end
                cyc1++;
            end
        end
    end

    initial begin
        int waited;
        rst0 = 1'b1; rst1 = 1'b1; rdy0 = 1'b0; rdy1 = 1'b0; op0 = '0; op1 = '0;
        for (int d = 0; d < 2; d++) begin
            add_reset(d, 2);
            for (int c = 0; c < 6; c++) gen_instr(d, c, 1'b0);
            // Directed mid-instruction resets: during MEMRD (LW) and ALUWB (R-type).
            push_plan(d, mk(1'b0, 1'b1, 6'h15, phase_out(P_FETCH, 1'b1, 1'b0)));
            push_plan(d, mk(1'b0, 1'b0, 6'b100011, phase_out(P_DECODE, 1'b1, 1'b0)));
            push_plan(d, mk(1'b0, 1'b0, 6'b100011, phase_out(P_MEMADR, 1'b1, 1'b0)));
            add_reset(d, 1);
            push_plan(d, mk(1'b0, 1'b1, 6'h2a, phase_out(P_FETCH, 1'b1, 1'b0)));
            push_plan(d, mk(1'b0, 1'b0, 6'b000000, phase_out(P_DECODE, 1'b1, 1'b0)));
            push_plan(d, mk(1'b0, 1'b0, 6'h3f, phase_out(P_EXEC, 1'b1, 1'b0)));
            add_reset(d, 2);
            for (int i = 0; i < 150; i++) gen_instr(d, -1, 1'b1);
        end
        waited = 0;
        while ((pq0.size() > 0 || pq1.size() > 0 || eq0.size() > 0 || eq1.size() > 0) &&
               waited < 20000) begin
            @(posedge clk);
            waited++;
        end
        @(negedge clk);
        #1;
        if (pq0.size() > 0 || pq1.size() > 0 || eq0.size() > 0 || eq1.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: %0d cycles still pending, required 0",
                     pq0.size() + pq1.size() + eq0.size() + eq1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
